// File: rtl/accel_dma_if.sv
// Packet channels between the copy sequencer (master side) and the AXI master bridge (slave side).
// Each channel moves one packet per cycle when access is high and wait is low.
interface accel_dma_if #(
    parameter int PW = 104
) ();
    logic          m_rd_access;
    logic [PW-1:0] m_rd_packet;
    logic          m_rd_wait;
    logic          m_rr_access;
    logic [PW-1:0] m_rr_packet;
    logic          m_rr_wait;
    logic          m_wr_access;
    logic [PW-1:0] m_wr_packet;
    logic          m_wr_wait;

    modport master (
        output m_rd_access,
        output m_rd_packet,
        input  m_rd_wait,
        input  m_rr_access,
        input  m_rr_packet,
        output m_rr_wait,
        output m_wr_access,
        output m_wr_packet,
        input  m_wr_wait
    );

    modport slave (
        input  m_rd_access,
        input  m_rd_packet,
        output m_rd_wait,
        output m_rr_access,
        output m_rr_packet,
        input  m_rr_wait,
        input  m_wr_access,
        input  m_wr_packet,
        output m_wr_wait
    );
endinterface

// File: rtl/accel_dma_sequencer.sv
// Copy engine: issues word reads from src whose return address is dst, then
// forwards each read response as a write packet. Bounded outstanding reads.
module accel_dma_sequencer #(
    parameter int AW      = 32,
    parameter int PW      = 2*AW + 40,
    parameter int CW      = 16,
    parameter int MAX_OUT = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [AW-1:0] cfg_src,
    input  logic [AW-1:0] cfg_dst,
    input  logic [CW-1:0] cfg_count,
    output logic          busy,
    output logic          done,
    accel_dma_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0]    MAX_OUT_L  = 8'(MAX_OUT);
    localparam logic [AW-1:0] WORD_BYTES = AW'(4);

    state_t        state, state_n;
    logic [CW-1:0] rd_left, rd_left_n;
    logic [CW-1:0] wr_left, wr_left_n;
    logic [7:0]    outstanding, outstanding_n;
    logic [AW-1:0] rd_addr, rd_addr_n;
    logic [AW-1:0] wr_addr, wr_addr_n;
    logic          rd_valid, rd_valid_n;
    logic [PW-1:0] rd_packet, rd_packet_n;
    logic          wr_valid, wr_valid_n;
    logic [PW-1:0] wr_packet, wr_packet_n;
    logic          busy_n, done_n;
    logic          rd_fire, rr_fire, rr_take, wr_fire;
    logic          rr_unused;

    // Layout: write | datamode | ctrlmode | dstaddr | data | srcaddr, LSB first.
    function automatic logic [PW-1:0] make_packet(
        input logic          write,
        input logic [AW-1:0] dstaddr,
        input logic [AW-1:0] data,
        input logic [AW-1:0] srcaddr
    );
        logic [PW-1:0] p;
        p                  = '0;
        p[0]               = write;
        p[2:1]             = 2'b10;
        p[AW+7:8]          = dstaddr;
        p[2*AW+7:AW+8]     = data;
        p[3*AW+7:2*AW+8]   = srcaddr;
        return p;
    endfunction

    assign rd_fire       = rd_valid & ~bus.m_rd_wait;
    assign wr_fire       = wr_valid & ~bus.m_wr_wait;
    // The write stage can take a new response in the same cycle its entry drains.
    assign bus.m_rr_wait = wr_valid & bus.m_wr_wait;
    assign rr_fire       = bus.m_rr_access & ~bus.m_rr_wait;
    assign rr_take       = rr_fire & ((state == RUN) || (state == DRAIN));
    assign rr_unused     = ^{bus.m_rr_packet[7:0], bus.m_rr_packet[PW-1:2*AW+8]};

    assign bus.m_rd_access = rd_valid;
    assign bus.m_rd_packet = rd_packet;
    assign bus.m_wr_access = wr_valid;
    assign bus.m_wr_packet = wr_packet;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_n       = state;
        rd_left_n     = rd_left;
        wr_left_n     = wr_left;
        outstanding_n = outstanding;
        rd_addr_n     = rd_addr;
        wr_addr_n     = wr_addr;
        wr_valid_n    = wr_valid;
        wr_packet_n   = wr_packet;

        if (rd_fire) begin
            rd_left_n = rd_left - CW'(1);
            rd_addr_n = rd_addr + WORD_BYTES;
            wr_addr_n = wr_addr + WORD_BYTES;
        end
        if (wr_fire) begin
            wr_left_n = wr_left - CW'(1);
        end

        case ({rd_fire, rr_take})
            2'b10:   outstanding_n = outstanding + 8'd1;
            2'b01:   outstanding_n = outstanding - 8'd1;
            default: outstanding_n = outstanding;
        endcase

        if (rr_take) begin
            wr_valid_n  = 1'b1;
            wr_packet_n = make_packet(1'b1, bus.m_rr_packet[AW+7:8],
                                      bus.m_rr_packet[2*AW+7:AW+8], '0);
        end else if (wr_fire) begin
            wr_valid_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    rd_left_n     = cfg_count;
                    wr_left_n     = cfg_count;
                    rd_addr_n     = cfg_src;
                    wr_addr_n     = cfg_dst;
                    outstanding_n = '0;
                    state_n       = (cfg_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_fire && (rd_left_n == '0)) begin
                    state_n = (wr_left_n == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (wr_left_n == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Registered outputs are decided from next-cycle values so they line up with the state.
        rd_valid_n  = (state_n == RUN) && (rd_left_n != '0) && (outstanding_n < MAX_OUT_L);
        rd_packet_n = rd_valid_n ? make_packet(1'b0, rd_addr_n, '0, wr_addr_n) : rd_packet;
        busy_n      = (state_n == RUN) || (state_n == DRAIN);
        done_n      = (state_n == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            rd_left     <= '0;
            wr_left     <= '0;
            outstanding <= '0;
            rd_addr     <= '0;
            wr_addr     <= '0;
            rd_valid    <= 1'b0;
            rd_packet   <= '0;
            wr_valid    <= 1'b0;
            wr_packet   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            rd_left     <= rd_left_n;
            wr_left     <= wr_left_n;
            outstanding <= outstanding_n;
            rd_addr     <= rd_addr_n;
            wr_addr     <= wr_addr_n;
            rd_valid    <= rd_valid_n;
            rd_packet   <= rd_packet_n;
            wr_valid    <= wr_valid_n;
            wr_packet   <= wr_packet_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end
endmodule

// File: tb/tb_accel_dma_sequencer.sv
// Bench for accel_dma_sequencer: a table of copy jobs run against a bridge/memory
// model with configurable latency and stalls, plus hand-written reset/zero-count sequences.
module tb_accel_dma_sequencer;
    localparam int AW      = 32;
    localparam int PW      = 2*AW + 40;
    localparam int CW      = 16;
    localparam int MAX_OUT = 2;

    typedef struct {
        string         name;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [CW-1:0] count;
        int            lat;
        int            rd_lo;
        int            rd_hi;
        int            wr_lo;
        int            wr_hi;
        int            spur_cyc;
        int            exp_done;
        int            exp_max_out;
        int            exp_rr_wait;
        logic [AW-1:0] exp_last_rd;
    } copy_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] ret;
        int            due;
    } req_t;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_src = '0;
    logic [AW-1:0] cfg_dst = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          busy;
    logic          done;

    accel_dma_if #(.PW(PW)) bus ();

    accel_dma_sequencer #(.AW(AW), .PW(PW), .CW(CW), .MAX_OUT(MAX_OUT)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .start     (start),
        .cfg_src   (cfg_src),
        .cfg_dst   (cfg_dst),
        .cfg_count (cfg_count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            lat = 0;
    int            rd_lo = 0, rd_hi = 0, wr_lo = 0, wr_hi = 0;
    int            rr_wait_cyc = 0;
    req_t          q[$];
    copy_t         tbl[6];
    bit            rd_f, rr_f, wr_f;
    bit            rd_stall_prev = 1'b0, wr_stall_prev = 1'b0;
    logic [PW-1:0] rd_pkt_s, wr_pkt_s, rd_prev, wr_prev;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    function automatic logic [PW-1:0] rd_exp(input logic [AW-1:0] addr, input logic [AW-1:0] ret);
        return {ret, {AW{1'b0}}, addr, 5'd0, 2'b10, 1'b0};
    endfunction

    function automatic logic [PW-1:0] wr_exp(input logic [AW-1:0] dst, input logic [AW-1:0] data);
        return {{AW{1'b0}}, data, dst, 5'd0, 2'b10, 1'b1};
    endfunction

    // Response as the bridge returns it: srcaddr/ctrlmode carry junk the sequencer must not forward.
    function automatic logic [PW-1:0] rsp_pkt(input logic [AW-1:0] dst, input logic [AW-1:0] data);
        return {32'hDEAD_BEEF, data, dst, 5'h1F, 2'b10, 1'b1};
    endfunction

    task automatic set_model(input int l, input int rl, input int rh, input int wl, input int wh);
        lat = l; rd_lo = rl; rd_hi = rh; wr_lo = wl; wr_hi = wh;
        bus.m_rd_wait = 1'b0;
        bus.m_wr_wait = 1'b0;
    endtask

    // One clock: sample handshakes at the falling edge, then advance the bridge model after the rising edge.
    task automatic tick();
        @(negedge clk);
        rd_f     = bus.m_rd_access && !bus.m_rd_wait;
        rr_f     = bus.m_rr_access && !bus.m_rr_wait;
        wr_f     = bus.m_wr_access && !bus.m_wr_wait;
        rd_pkt_s = bus.m_rd_packet;
        wr_pkt_s = bus.m_wr_packet;
        if (bus.m_rr_wait) rr_wait_cyc++;
        if (rd_stall_prev) begin
            check("rd_hold_access", PW'(bus.m_rd_access), PW'(1));
            check("rd_hold_packet", bus.m_rd_packet, rd_prev);
        end
        if (wr_stall_prev) begin
            check("wr_hold_access", PW'(bus.m_wr_access), PW'(1));
            check("wr_hold_packet", bus.m_wr_packet, wr_prev);
        end
        rd_stall_prev = bus.m_rd_access && bus.m_rd_wait;
        wr_stall_prev = bus.m_wr_access && bus.m_wr_wait;
        rd_prev       = bus.m_rd_packet;
        wr_prev       = bus.m_wr_packet;

        @(posedge clk);
        #1;
        cyc++;
        if (rd_f) q.push_back('{addr: rd_pkt_s[AW+7:8], ret: rd_pkt_s[3*AW+7:2*AW+8], due: cyc + lat});
        if (rr_f && q.size() > 0) void'(q.pop_front());
        start         = 1'b0;
        bus.m_rd_wait = (rd_hi != 0) && (cyc >= rd_lo) && (cyc <= rd_hi);
        bus.m_wr_wait = (wr_hi != 0) && (cyc >= wr_lo) && (cyc <= wr_hi);
        if (q.size() > 0 && q[0].due <= cyc) begin
            bus.m_rr_access = 1'b1;
            bus.m_rr_packet = rsp_pkt(q[0].ret, mem_word(q[0].addr));
        end else begin
            bus.m_rr_access = 1'b0;
            bus.m_rr_packet = '0;
        end
    endtask

    task automatic run_copy(input copy_t c);
        int            nrd, nwr, outst, max_out, done_cyc, pulses;
        logic [AW-1:0] last_rd;
        nrd = 0; nwr = 0; outst = 0; max_out = 0; done_cyc = -1; pulses = 0;
        last_rd = '0;
        set_model(c.lat, c.rd_lo, c.rd_hi, c.wr_lo, c.wr_hi);
        rr_wait_cyc = 0;
        cfg_src = c.src; cfg_dst = c.dst; cfg_count = c.count;
        start = 1'b1;
        cyc = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (rd_f) begin
                check({c.name, ".rd_pkt"}, rd_pkt_s,
                      rd_exp(c.src + AW'(4*nrd), c.dst + AW'(4*nrd)));
                last_rd = rd_pkt_s[AW+7:8];
                nrd++;
                outst++;
            end
            if (rr_f) outst--;
            if (outst > max_out) max_out = outst;
            if (wr_f) begin
                check({c.name, ".wr_pkt"}, wr_pkt_s,
                      wr_exp(c.dst + AW'(4*nwr), mem_word(c.src + AW'(4*nwr))));
                nwr++;
            end
            if (cyc == 1) begin
                check({c.name, ".busy_c1"}, PW'(busy), PW'(1));
                check({c.name, ".rd_access_c1"}, PW'(bus.m_rd_access), PW'(1));
            end
            if (cyc == c.spur_cyc) begin
                start = 1'b1; cfg_src = 32'h9000; cfg_dst = 32'hA000; cfg_count = 16'd2;
            end
            if (done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({c.name, ".busy_at_done"}, PW'(busy), PW'(0));
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        check({c.name, ".done_cycle"}, PW'(done_cyc), PW'(c.exp_done));
        check({c.name, ".done_pulses"}, PW'(pulses), PW'(1));
        check({c.name, ".reads"}, PW'(nrd), PW'(c.count));
        check({c.name, ".writes"}, PW'(nwr), PW'(c.count));
        check({c.name, ".max_outstanding"}, PW'(max_out), PW'(c.exp_max_out));
        check({c.name, ".rr_wait_cycles"}, PW'(rr_wait_cyc), PW'(c.exp_rr_wait));
        check({c.name, ".last_rd_addr"}, PW'(last_rd), PW'(c.exp_last_rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, n_rr;
        //          name      src            dst           cnt  lat rdlo rdhi wrlo wrhi spur done maxo rrw last_rd
        tbl[0] = '{"basic",  32'h0000_1000, 32'h0000_2000, 16'd4, 0,  0,   0,   0,   0,   3,   7,   1,   0,  32'h0000_100C};
        tbl[1] = '{"latency", 32'h0000_4000, 32'h0000_8000, 16'd6, 10, 0,   0,   0,   0,   0,   39,  2,   0,  32'h0000_4014};
        tbl[2] = '{"wr_stall", 32'h0000_1100, 32'h0000_2200, 16'd6, 0, 0,   0,   4,   8,   0,   14,  2,   5,  32'h0000_1114};
        tbl[3] = '{"wrap",   32'hFFFF_FFF8, 32'h0000_3000, 16'd4, 0,  0,   0,   0,   0,   0,   7,   1,   0,  32'h0000_0004};
        tbl[4] = '{"rd_stall", 32'h0000_0500, 32'h0000_0600, 16'd3, 0, 2,   3,   0,   0,   0,   8,   1,   0,  32'h0000_0508};
        tbl[5] = '{"single", 32'h0000_0700, 32'h0000_0780, 16'd1, 3,  0,   0,   0,   0,   0,   7,   1,   0,  32'h0000_0700};

        set_model(0, 0, 0, 0, 0);
        bus.m_rr_access = 1'b0;
        bus.m_rr_packet = '0;
        nreset = 1'b0;
        #2;
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_done", PW'(done), PW'(0));
        check("rst_rd_access", PW'(bus.m_rd_access), PW'(0));
        check("rst_wr_access", PW'(bus.m_wr_access), PW'(0));
        check("rst_rd_packet", bus.m_rd_packet, '0);
        check("rst_wr_packet", bus.m_wr_packet, '0);
        check("rst_rr_wait", PW'(bus.m_rr_wait), PW'(0));
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_copy(tbl[i]);
            repeat (2) tick();
        end

        // Zero count: done at cycle 1, start during DONE ignored, accepted again one cycle later.
        set_model(0, 0, 0, 0, 0);
        n_acc = 0;
        cfg_src = 32'hB000; cfg_dst = 32'hC000; cfg_count = 16'd0;
        start = 1'b1;
        cyc = 0;
        tick();
        check("zero.done_c1", PW'(done), PW'(1));
        check("zero.busy_c1", PW'(busy), PW'(0));
        check("zero.rd_access_c1", PW'(bus.m_rd_access), PW'(0));
        cfg_count = 16'd3;
        start = 1'b1;
        tick();
        check("zero.start_in_done_ignored", PW'(busy), PW'(0));
        check("zero.done_c2", PW'(done), PW'(0));
        cfg_count = 16'd0;
        start = 1'b1;
        tick();
        check("zero.restart_done_c3", PW'(done), PW'(1));
        repeat (4) begin
            tick();
            if (rd_f || wr_f) n_acc++;
        end
        check("zero.no_access", PW'(n_acc), PW'(0));

        // Reset in the middle of a copy, then two late responses arrive while idle.
        set_model(10, 0, 0, 0, 0);
        cfg_src = 32'h1000; cfg_dst = 32'h2000; cfg_count = 16'd4;
        start = 1'b1;
        cyc = 0;
        repeat (4) tick();
        check("rst_mid.busy_before", PW'(busy), PW'(1));
        nreset = 1'b0;
        #1;
        check("rst_mid.busy", PW'(busy), PW'(0));
        check("rst_mid.done", PW'(done), PW'(0));
        check("rst_mid.rd_access", PW'(bus.m_rd_access), PW'(0));
        check("rst_mid.wr_access", PW'(bus.m_wr_access), PW'(0));
        check("rst_mid.rd_packet", bus.m_rd_packet, '0);
        check("rst_mid.wr_packet", bus.m_wr_packet, '0);
        check("rst_mid.rr_wait", PW'(bus.m_rr_wait), PW'(0));
        repeat (2) tick();
        nreset = 1'b1;
        n_acc = 0;
        n_rr  = 0;
        repeat (14) begin
            tick();
            if (rd_f || wr_f) n_acc++;
            if (rr_f) n_rr++;
        end
        check("rst_mid.late_rsp_accepted", PW'(n_rr), PW'(2));
        check("rst_mid.no_packets", PW'(n_acc), PW'(0));
        check("rst_mid.busy_after", PW'(busy), PW'(0));

        run_copy(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
